// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair.
// State encoding, default taps and the next-word prediction function.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEED    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int DW_DEF    = 6;
  localparam int TAP_A_DEF = 4;
  localparam int TAP_B_DEF = 1;

  // Shift left by one, feed back tap_a ^ tap_b into bit 0,
  // then mask to the live word width.
  function automatic logic [63:0] nxt(
    input logic [63:0] x,
    input int          dw,
    input int          ta,
    input int          tb
  );
    logic [63:0] mask;
    logic        fb;
    mask = (64'd1 << dw) - 64'd1;
    fb   = x[ta] ^ x[tb];
    return ((x << 1) | {63'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/prbs_err_ctr.sv
// Saturating error counter with synchronous clear (clear wins).
// PRBS_CHK_BITERR_EN: add popcount(diff) per hit instead of 1.
module prbs_err_ctr #(
  parameter int DW = 6,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [DW-1:0] diff,
  output logic [CW-1:0] cnt
);

  localparam int AW = $clog2(DW + 1);
  localparam int SW = CW + 1;

  logic [AW-1:0] amt;
  logic [SW-1:0] sum;

`ifdef PRBS_CHK_BITERR_EN
  always_comb begin
    amt = '0;
    for (int i = 0; i < DW; i++) begin
      amt = amt + AW'(diff[i]);
    end
  end
`else
  logic unused_diff;
  assign unused_diff = ^diff;
  assign amt = AW'(1);
`endif

  // One spare MSB catches the wrap for saturation.
  assign sum = {1'b0, cnt} + SW'(amt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sum[CW] ? '1 : sum[CW-1:0];
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-seeding PRBS checker: SEED -> LOCKING -> LOCKED, loss on error burst.
// PRBS_CHK_BITERR_EN makes the error counter count bit errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int DW_LFSR  = DW_DEF,
  parameter int TAP_A    = TAP_A_DEF,
  parameter int TAP_B    = TAP_B_DEF,
  parameter int LOCK_THR = 4,
  parameter int LOSS_THR = 3,
  parameter int CW       = 16
) (
  input  logic               i_clk_prbs_chk,
  input  logic               i_rst_n_prbs_chk,
  input  logic               i_vld_prbs_chk,
  input  logic [DW_LFSR-1:0] i_data_prbs_chk,
  input  logic               i_clr_prbs_chk,
  output logic               o_locked_prbs_chk,
  output logic               o_err_prbs_chk,
  output logic [CW-1:0]      o_err_cnt_prbs_chk
);

  localparam int MW = $clog2(LOCK_THR + 1);
  localparam int LW = $clog2(LOSS_THR + 1);

  state_t             st;
  state_t             st_d;
  logic [DW_LFSR-1:0] exp_q;
  logic [DW_LFSR-1:0] exp_d;
  logic [MW-1:0]      match_q;
  logic [MW-1:0]      match_d;
  logic [LW-1:0]      miss_q;
  logic [LW-1:0]      miss_d;
  logic               err_q;
  logic               err_d;

  logic [DW_LFSR-1:0] pred_w;
  logic [DW_LFSR-1:0] pred_e;
  logic               hit;
  logic               zero;

  assign pred_w = DW_LFSR'(nxt(64'(i_data_prbs_chk), DW_LFSR, TAP_A, TAP_B));
  assign pred_e = DW_LFSR'(nxt(64'(exp_q), DW_LFSR, TAP_A, TAP_B));
  assign hit    = (i_data_prbs_chk == exp_q);
  assign zero   = (i_data_prbs_chk == '0);

  always_ff @(posedge i_clk_prbs_chk or negedge i_rst_n_prbs_chk) begin
    if (!i_rst_n_prbs_chk) begin
      st      <= ST_SEED;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      st      <= st_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    st_d    = st;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    if (i_vld_prbs_chk) begin
      unique case (st)
        ST_SEED: begin
          if (!zero) begin
            exp_d   = pred_w;
            match_d = '0;
            st_d    = ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          if (hit) begin
            exp_d   = pred_w;
            match_d = match_q + 1'b1;
            if (match_q == MW'(LOCK_THR - 1)) begin
              st_d = ST_LOCKED;
            end
          end else if (zero) begin
            st_d = ST_SEED;
          end else begin
            exp_d   = pred_w;
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel on our own prediction so one bad word counts once.
          exp_d = pred_e;
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (miss_q == LW'(LOSS_THR - 1)) begin
              st_d   = ST_SEED;
              miss_d = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: begin
          st_d = ST_SEED;
        end
      endcase
    end
  end

  prbs_err_ctr #(
    .DW (DW_LFSR),
    .CW (CW)
  ) u_err_ctr (
    .clk   (i_clk_prbs_chk),
    .rst_n (i_rst_n_prbs_chk),
    .clr   (i_clr_prbs_chk),
    .inc   (err_d),
    .diff  (i_data_prbs_chk ^ exp_q),
    .cnt   (o_err_cnt_prbs_chk)
  );

  assign o_locked_prbs_chk = (st == ST_LOCKED);
  assign o_err_prbs_chk    = err_q;

endmodule
